stream_join_n: RTL and testbench

- Joins NUM_CH independent valid/ready input streams into one output beat.
- Each channel is buffered in its own small FIFO.
- A joined output beat is presented only when every enabled channel holds data; one output transfer pops all enabled channels at once.
- Sits between parallel producers (e.g. per-lane compute results) and a single wide consumer.
- Generalises a plain combinational "valid = a && b" join to N channels, with buffering, backpressure, a channel mask and a transfer counter.

---
 rtl/stream_join_pkg.sv | 19 +
 rtl/sync_fifo_sc.sv | 61 ++++++
 rtl/stream_join_n.sv | 80 ++++++++
 tb/tb_stream_join_n.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/stream_join_pkg.sv
// Shared definitions for the stream_join_n block.
//   cnt_w()       : occupancy counter width for a FIFO of a given depth
//   DEF_*         : default parameter values used by the block
//   def_slice_t   : one channel's data slice at the default width
package stream_join_pkg;

    localparam int unsigned DEF_NUM_CH = 4;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_DEPTH  = 4;
    localparam int unsigned DEF_CNT_W  = 16;

    typedef logic [DEF_DATA_W-1:0] def_slice_t;

    // One extra bit so a full FIFO (count == depth) is representable.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_sc.sv
// Single-clock FIFO with registered pointers and occupancy count.
//   clk, rst_n : clock, asynchronous active-low reset (clears pointers/count)
//   push/wdata : write one entry (caller guarantees not full)
//   pop        : drop the head entry (caller guarantees not empty)
//   head       : current head entry
//   count      : number of stored entries, 0..DEPTH
module sync_fifo_sc #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Power-of-two depth: pointers wrap by natural overflow.
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wdata;
    end

    assign head  = mem[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/stream_join_n.sv
// N-way valid/ready stream join with per-channel buffering.
//   ch_en     : per-channel enable; disabled channels accept and drop input
//   in_valid/in_ready/in_data : NUM_CH input streams, channel i at [i*DATA_W +: DATA_W]
//   out_valid/out_ready/out_data : joined beat of all enabled heads (disabled slices 0)
//   xfer_cnt  : saturating count of output transfers; clr_cnt clears it (priority)
module stream_join_n
    import stream_join_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]         xfer_cnt,
    input  logic                     clr_cnt
);
    localparam int unsigned CW = cnt_w(DEPTH);

    logic [DATA_W-1:0] head [NUM_CH];
    logic [CW-1:0]     count [NUM_CH];
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic              fire;
    logic [CNT_W-1:0]  xfer_cnt_q, xfer_cnt_d;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        sync_fifo_sc #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[i]),
            .wdata (in_data[i*DATA_W +: DATA_W]),
            .pop   (pop[i]),
            .head  (head[i]),
            .count (count[i])
        );
    end

    always_comb begin
        in_ready  = '0;
        push      = '0;
        pop       = '0;
        out_data  = '0;
        out_valid = |ch_en;
        for (int i = 0; i < NUM_CH; i++) begin
            // Full blocks the push even if a pop happens this cycle.
            in_ready[i] = rst_n && (ch_en[i] ? (count[i] != CW'(DEPTH)) : 1'b1);
            push[i]     = in_valid[i] && in_ready[i] && ch_en[i];
            if (ch_en[i] && count[i] == '0) out_valid = 1'b0;
            if (ch_en[i] && rst_n) out_data[i*DATA_W +: DATA_W] = head[i];
        end
        fire = out_valid && out_ready;
        pop  = fire ? ch_en : '0;
    end

    always_comb begin
        xfer_cnt_d = xfer_cnt_q;
        if (clr_cnt)                        xfer_cnt_d = '0;
        else if (fire && xfer_cnt_q != '1)  xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) xfer_cnt_q <= '0;
        else        xfer_cnt_q <= xfer_cnt_d;
    end

    assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_stream_join_n.sv
// Directed self-checking bench for stream_join_n (NUM_CH=4, DATA_W=8, DEPTH=4, CNT_W=4).
module tb_stream_join_n;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  ch_en;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  xfer_cnt;
    logic        clr_cnt;

    int total = 0;
    int bad   = 0;

    stream_join_n #(
        .NUM_CH (4),
        .DATA_W (8),
        .DEPTH  (4),
        .CNT_W  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ch_en     (ch_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .xfer_cnt  (xfer_cnt),
        .clr_cnt   (clr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; sample/drive 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] beat(input int n);
        logic [7:0] b;
        b = 8'(n);
        return {b + 8'h30, b + 8'h20, b + 8'h10, b};
    endfunction

    initial begin
        rst_n = 1'b0; ch_en = 4'hF; in_valid = '0; in_data = '0;
        out_ready = 1'b0; clr_cnt = 1'b0;
        #3;
        chk("rst_in_ready", 64'(in_ready), 64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_data", 64'(out_data), 64'h0);
        chk("rst_xfer_cnt", 64'(xfer_cnt), 64'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_in_ready", 64'(in_ready), 64'hF);

        // 1: basic join, one channel per cycle
        out_ready = 1'b1;
        in_valid = 4'b0001; in_data = 32'h0000_0011; tick();
        chk("t1_not_yet", 64'(out_valid), 64'h0);
        in_valid = 4'b0010; in_data = 32'h0000_2200; tick();
        in_valid = 4'b0100; in_data = 32'h0033_0000; tick();
        chk("t1_not_yet3", 64'(out_valid), 64'h0);
        in_valid = 4'b1000; in_data = 32'h4400_0000; tick();
        in_valid = '0;
        chk("t1_valid", 64'(out_valid), 64'h1);
        chk("t1_data", 64'(out_data), 64'h44332211);
        tick();
        chk("t1_cnt", 64'(xfer_cnt), 64'h1);
        chk("t1_empty", 64'(out_valid), 64'h0);

        // 2: backpressure fill to DEPTH then drain
        out_ready = 1'b0; in_valid = 4'hF;
        for (int b = 0; b < 4; b++) begin
            chk("t2_ready_fill", 64'(in_ready), 64'hF);
            in_data = 32'h1312_1110 + 32'h1010_1010 * 32'(b);
            tick();
        end
        chk("t2_full_ready", 64'(in_ready), 64'h0);
        in_data = 32'h5555_5555; tick();
        chk("t2_full_hold", 64'(in_ready), 64'h0);
        in_valid = '0; out_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            chk("t2_drain_valid", 64'(out_valid), 64'h1);
            chk("t2_drain_data", 64'(out_data), 64'(32'h1312_1110 + 32'h1010_1010 * 32'(b)));
            tick();
            chk("t2_ready_back", 64'(in_ready), 64'hF);
        end
        chk("t2_done", 64'(out_valid), 64'h0);
        chk("t2_cnt", 64'(xfer_cnt), 64'h5);

        // 3: channel mask
        out_ready = 1'b0; ch_en = 4'b0101;
        in_valid = 4'hF; in_data = 32'hFFBB_FFAA;
        chk("t3_ready", 64'(in_ready), 64'hF);
        tick();
        in_valid = '0;
        chk("t3_valid", 64'(out_valid), 64'h1);
        chk("t3_data", 64'(out_data), 64'h00BB00AA);
        chk("t3_ready_after", 64'(in_ready), 64'hF);
        out_ready = 1'b1; tick();
        chk("t3_cnt", 64'(xfer_cnt), 64'h6);
        chk("t3_drained", 64'(out_valid), 64'h0);
        ch_en = 4'hF; #1;
        chk("t3_no_dropped", 64'(out_valid), 64'h0);
        ch_en = 4'h0; #1;
        chk("t3_en0_valid", 64'(out_valid), 64'h0);
        chk("t3_en0_ready", 64'(in_ready), 64'hF);
        ch_en = 4'hF;

        // 4: steady-state streaming
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        chk("t4_clr", 64'(xfer_cnt), 64'h0);
        in_valid = 4'hF; out_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            in_data = beat(n);
            tick();
            chk("t4_valid", 64'(out_valid), 64'h1);
            chk("t4_data", 64'(out_data), 64'(beat(n)));
            chk("t4_cnt", 64'(xfer_cnt), 64'(n));
        end
        in_valid = '0; tick();
        chk("t4_final_cnt", 64'(xfer_cnt), 64'h8);
        chk("t4_empty", 64'(out_valid), 64'h0);

        // 5: reset mid-operation
        out_ready = 1'b0; in_valid = 4'hF;
        in_data = beat(100); tick();
        in_data = beat(101); tick();
        in_valid = '0;
        chk("t5_buffered", 64'(out_valid), 64'h1);
        #2 rst_n = 1'b0; #1;
        chk("t5_rst_valid", 64'(out_valid), 64'h0);
        chk("t5_rst_cnt", 64'(xfer_cnt), 64'h0);
        chk("t5_rst_ready", 64'(in_ready), 64'h0);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("t5_no_stale", 64'(out_valid), 64'h0);
        tick();
        chk("t5_no_stale2", 64'(out_valid), 64'h0);
        chk("t5_cnt_zero", 64'(xfer_cnt), 64'h0);
        in_valid = 4'hF; in_data = beat(7); tick();
        in_valid = '0;
        chk("t5_fresh_data", 64'(out_data), 64'(beat(7)));
        tick();
        chk("t5_fresh_cnt", 64'(xfer_cnt), 64'h1);

        // 6: counter saturation, then clear alongside a transfer
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        in_valid = 4'hF; out_ready = 1'b1;
        for (int n = 0; n < 22; n++) begin
            in_data = beat(n);
            tick();
            chk("t6_sat", 64'(xfer_cnt), 64'((n > 15) ? 15 : n));
        end
        chk("t6_valid", 64'(out_valid), 64'h1);
        clr_cnt = 1'b1; in_valid = '0; tick(); clr_cnt = 1'b0;
        chk("t6_clr", 64'(xfer_cnt), 64'h0);
        chk("t6_popped", 64'(out_valid), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
